// File: rtl/tdm_demux1_to_4_pkg.sv
// rtl/tdm_demux1_to_4_pkg.sv - shared state/slot types for the TDM 1-to-4 demultiplexer
package tdm_demux1_to_4_pkg;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SLOT0 = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2,
        SLOT3 = 2'd3
    } slot_t;

    function automatic logic [3:0] slot_onehot(input slot_t slot);
        return 4'b0001 << slot;
    endfunction

endpackage

// File: rtl/tdm_demux1_to_4_if.sv
// rtl/tdm_demux1_to_4_if.sv - TDM input stream, mode/select controls and channel outputs
interface tdm_demux1_to_4_if #(
    parameter int WIDTH  = 3,
    parameter int FCNT_W = 8
);
    logic [WIDTH-1:0]  in_data;
    logic              in_valid;
    logic              in_sync;
    logic              auto_mode;
    logic              s1;
    logic              s0;
    logic [WIDTH-1:0]  out0;
    logic [WIDTH-1:0]  out1;
    logic [WIDTH-1:0]  out2;
    logic [WIDTH-1:0]  out3;
    logic [3:0]        out_valid;
    logic              frame_done;
    logic              sync_err;
    logic [FCNT_W-1:0] frame_cnt;

    modport master (
        output in_data, in_valid, in_sync, auto_mode, s1, s0,
        input  out0, out1, out2, out3, out_valid, frame_done, sync_err, frame_cnt
    );

    modport slave (
        input  in_data, in_valid, in_sync, auto_mode, s1, s0,
        output out0, out1, out2, out3, out_valid, frame_done, sync_err, frame_cnt
    );
endinterface

// File: rtl/tdm_demux1_to_4_slot_ctrl.sv
// rtl/tdm_demux1_to_4_slot_ctrl.sv - AUTO-mode framing FSM, slot counter and frame counter
module tdm_demux1_to_4_slot_ctrl
    import tdm_demux1_to_4_pkg::*;
#(
    parameter int FCNT_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              auto_mode,
    input  logic              in_valid,
    input  logic              in_sync,
    output logic [3:0]        we,
    output logic              frame_done,
    output logic              sync_err,
    output logic [FCNT_W-1:0] frame_cnt
);

    state_t            state, state_n;
    slot_t             slot, slot_n;
    logic              frame_done_n;
    logic              sync_err_n;
    logic [FCNT_W-1:0] frame_cnt_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_HUNT;
            slot       <= SLOT0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_n;
            slot       <= slot_n;
            frame_done <= frame_done_n;
            sync_err   <= sync_err_n;
            frame_cnt  <= frame_cnt_n;
        end
    end

    // MANUAL parks the FSM in HUNT, so entering AUTO always starts by hunting for sync
    always_comb begin
        state_n      = state;
        slot_n       = slot;
        we           = 4'b0000;
        frame_done_n = 1'b0;
        sync_err_n   = 1'b0;
        frame_cnt_n  = frame_cnt;
        if (!auto_mode) begin
            state_n = ST_HUNT;
            slot_n  = SLOT0;
        end else if (in_valid) begin
            case (state)
                ST_HUNT: begin
                    if (in_sync) begin
                        we      = slot_onehot(SLOT0);
                        slot_n  = SLOT1;
                        state_n = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (in_sync) begin
                        we         = slot_onehot(SLOT0);
                        slot_n     = SLOT1;
                        sync_err_n = (slot != SLOT0);
                    end else if (slot == SLOT0) begin
                        sync_err_n = 1'b1;
                        state_n    = ST_HUNT;
                        slot_n     = SLOT0;
                    end else begin
                        we     = slot_onehot(slot);
                        slot_n = slot_t'(slot + 2'd1);
                        if (slot == SLOT3) begin
                            frame_done_n = 1'b1;
                            if (frame_cnt != {FCNT_W{1'b1}})
                                frame_cnt_n = frame_cnt + FCNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_n = ST_HUNT;
                    slot_n  = SLOT0;
                end
            endcase
        end
    end

endmodule

// File: rtl/tdm_demux1_to_4.sv
// rtl/tdm_demux1_to_4.sv - registered 1-to-4 TDM demultiplexer with AUTO (sync-locked) and MANUAL steering
module tdm_demux1_to_4
    import tdm_demux1_to_4_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int FCNT_W = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    tdm_demux1_to_4_if.slave   bus
);

    logic [3:0] ctrl_we;
    logic [3:0] we;

    tdm_demux1_to_4_slot_ctrl #(
        .FCNT_W (FCNT_W)
    ) u_slot_ctrl (
        .clock      (clock),
        .reset_n    (reset_n),
        .auto_mode  (bus.auto_mode),
        .in_valid   (bus.in_valid),
        .in_sync    (bus.in_sync),
        .we         (ctrl_we),
        .frame_done (bus.frame_done),
        .sync_err   (bus.sync_err),
        .frame_cnt  (bus.frame_cnt)
    );

    always_comb begin
        we = 4'b0000;
        if (bus.auto_mode)
            we = ctrl_we;
        else if (bus.in_valid)
            we = slot_onehot(slot_t'({bus.s1, bus.s0}));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.out0      <= '0;
            bus.out1      <= '0;
            bus.out2      <= '0;
            bus.out3      <= '0;
            bus.out_valid <= 4'b0000;
        end else begin
            bus.out_valid <= we;
            if (we[0]) bus.out0 <= bus.in_data;
            if (we[1]) bus.out1 <= bus.in_data;
            if (we[2]) bus.out2 <= bus.in_data;
            if (we[3]) bus.out3 <= bus.in_data;
        end
    end

endmodule
